// File: rtl/morse_symbol_decoder.sv
// -----------------------------------------------------------------------------
// morse_symbol_decoder
//
// Purpose:
//   Measures key-down (mark) and key-up (space) durations in units of the
//   `tick` strobe, classifies marks as dots or dashes and spaces as
//   intra-character, letter or word gaps, and assembles the elements of one
//   character into a code word that is presented with a one-cycle strobe.
//
// Ports:
//   clk        - clock, rising edge
//   reset_n    - asynchronous active-low reset
//   b          - key level (1 = pressed), already synchronous to clk
//   tick       - one-cycle time-unit strobe
//   dot_out    - one-cycle pulse per classified dot
//   dash_out   - one-cycle pulse per classified dash
//   lg         - one-cycle pulse on a letter gap
//   wg         - one-cycle pulse on a word gap
//   code       - element bits of the finished character (1 = dash, newest at LSB)
//   code_len   - number of valid elements in code
//   code_valid - one-cycle strobe qualifying code, code_len, code_err
//   code_err   - the character had more than MAX_SYM elements
//
// Build option:
//   MORSE_DEBOUNCE_EN - when defined, the key level is filtered so that it only
//   changes after b has held the new level for DEB_LEN consecutive ticks.
//   When undefined the key level is b itself and DEB_LEN is not used.
// -----------------------------------------------------------------------------
module morse_symbol_decoder #(
    parameter int CNT_W   = 16,
    parameter int DOT_MAX = 2,
    parameter int LG_MIN  = 3,
    parameter int WG_MIN  = 7,
    parameter int MAX_SYM = 6,
    parameter int DEB_LEN = 3
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         b,
    input  logic                         tick,
    output logic                         dot_out,
    output logic                         dash_out,
    output logic                         lg,
    output logic                         wg,
    output logic [MAX_SYM-1:0]           code,
    output logic [$clog2(MAX_SYM+1)-1:0] code_len,
    output logic                         code_valid,
    output logic                         code_err
);

    localparam int LEN_W = $clog2(MAX_SYM + 1);

    // Reject parameter sets that would make the gap thresholds meaningless.
    if (LG_MIN < 1 || WG_MIN <= LG_MIN || MAX_SYM < 2 || DEB_LEN < 1) begin : g_bad_params
        $error("morse_symbol_decoder: illegal parameter combination");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MARK  = 2'd1,
        SPACE = 2'd2,
        LGAP  = 2'd3
    } state_t;

    logic bl_s;

`ifdef MORSE_DEBOUNCE_EN
    localparam int DEB_W = $clog2(DEB_LEN + 1);

    logic             bl_r;
    logic [DEB_W-1:0] deb_cnt_r;

    // Debounce filter: adopt the new key level only after DEB_LEN ticks of agreement.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bl_r      <= 1'b0;
            deb_cnt_r <= {DEB_W{1'b0}};
        end else if (b == bl_r) begin
            deb_cnt_r <= {DEB_W{1'b0}};
        end else if (tick) begin
            if (deb_cnt_r == DEB_W'(DEB_LEN - 1)) begin
                bl_r      <= b;
                deb_cnt_r <= {DEB_W{1'b0}};
            end else begin
                deb_cnt_r <= deb_cnt_r + {{(DEB_W-1){1'b0}}, 1'b1};
            end
        end else begin
            deb_cnt_r <= deb_cnt_r;
        end
    end

    assign bl_s = bl_r;
`else
    assign bl_s = b;
`endif

    state_t               state_r,    state_n;
    logic [CNT_W-1:0]     cnt_r,      cnt_n;
    logic [MAX_SYM-1:0]   shreg_r,    shreg_n;
    logic [LEN_W-1:0]     len_r,      len_n;
    logic                 ovf_r,      ovf_n;
    logic                 dot_r,      dot_n;
    logic                 dash_r,     dash_n;
    logic                 lg_r,       lg_n;
    logic                 wg_r,       wg_n;
    logic [MAX_SYM-1:0]   code_r,     code_n;
    logic [LEN_W-1:0]     code_len_r, code_len_n;
    logic                 cv_r,       cv_n;
    logic                 err_r,      err_n;

    logic [CNT_W-1:0]     cnt_inc_s;
    logic                 is_dash_s;

    // The duration counter sticks at all-ones instead of wrapping.
    assign cnt_inc_s = (cnt_r == {CNT_W{1'b1}}) ? cnt_r : (cnt_r + {{(CNT_W-1){1'b0}}, 1'b1});
    assign is_dash_s = (cnt_r > CNT_W'(DOT_MAX));

    // Next-state and registered-output logic; a key edge always takes
    // priority over a coincident tick.
    always_comb begin
        state_n    = state_r;
        cnt_n      = cnt_r;
        shreg_n    = shreg_r;
        len_n      = len_r;
        ovf_n      = ovf_r;
        dot_n      = 1'b0;
        dash_n     = 1'b0;
        lg_n       = 1'b0;
        wg_n       = 1'b0;
        cv_n       = 1'b0;
        code_n     = code_r;
        code_len_n = code_len_r;
        err_n      = err_r;

        case (state_r)
            IDLE: begin
                if (bl_s) begin
                    state_n = MARK;
                    cnt_n   = {CNT_W{1'b0}};
                end else begin
                    state_n = IDLE;
                end
            end

            MARK: begin
                if (!bl_s) begin
                    dash_n = is_dash_s;
                    dot_n  = ~is_dash_s;
                    // A full code word keeps its contents; the extra element
                    // only marks the character as erroneous.
                    if (len_r == LEN_W'(MAX_SYM)) begin
                        ovf_n = 1'b1;
                    end else begin
                        shreg_n = {shreg_r[MAX_SYM-2:0], is_dash_s};
                        len_n   = len_r + {{(LEN_W-1){1'b0}}, 1'b1};
                    end
                    cnt_n   = {CNT_W{1'b0}};
                    state_n = SPACE;
                end else if (tick) begin
                    cnt_n = cnt_inc_s;
                end else begin
                    cnt_n = cnt_r;
                end
            end

            SPACE: begin
                if (bl_s) begin
                    state_n = MARK;
                    cnt_n   = {CNT_W{1'b0}};
                end else if (tick) begin
                    cnt_n = cnt_inc_s;
                    // Counter keeps running into LGAP so the word gap is
                    // measured from the start of the space.
                    if (cnt_inc_s == CNT_W'(LG_MIN)) begin
                        lg_n       = 1'b1;
                        cv_n       = 1'b1;
                        code_n     = shreg_r;
                        code_len_n = len_r;
                        err_n      = ovf_r;
                        shreg_n    = {MAX_SYM{1'b0}};
                        len_n      = {LEN_W{1'b0}};
                        ovf_n      = 1'b0;
                        state_n    = LGAP;
                    end else begin
                        state_n = SPACE;
                    end
                end else begin
                    cnt_n = cnt_r;
                end
            end

            LGAP: begin
                if (bl_s) begin
                    state_n = MARK;
                    cnt_n   = {CNT_W{1'b0}};
                end else if (tick) begin
                    cnt_n = cnt_inc_s;
                    if (cnt_inc_s == CNT_W'(WG_MIN)) begin
                        wg_n    = 1'b1;
                        state_n = IDLE;
                    end else begin
                        state_n = LGAP;
                    end
                end else begin
                    cnt_n = cnt_r;
                end
            end

            default: begin
                state_n = IDLE;
                cnt_n   = {CNT_W{1'b0}};
            end
        endcase
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= IDLE;
            cnt_r      <= {CNT_W{1'b0}};
            shreg_r    <= {MAX_SYM{1'b0}};
            len_r      <= {LEN_W{1'b0}};
            ovf_r      <= 1'b0;
            dot_r      <= 1'b0;
            dash_r     <= 1'b0;
            lg_r       <= 1'b0;
            wg_r       <= 1'b0;
            code_r     <= {MAX_SYM{1'b0}};
            code_len_r <= {LEN_W{1'b0}};
            cv_r       <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            state_r    <= state_n;
            cnt_r      <= cnt_n;
            shreg_r    <= shreg_n;
            len_r      <= len_n;
            ovf_r      <= ovf_n;
            dot_r      <= dot_n;
            dash_r     <= dash_n;
            lg_r       <= lg_n;
            wg_r       <= wg_n;
            code_r     <= code_n;
            code_len_r <= code_len_n;
            cv_r       <= cv_n;
            err_r      <= err_n;
        end
    end

    assign dot_out    = dot_r;
    assign dash_out   = dash_r;
    assign lg         = lg_r;
    assign wg         = wg_r;
    assign code       = code_r;
    assign code_len   = code_len_r;
    assign code_valid = cv_r;
    assign code_err   = err_r;

endmodule
